// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Access-type encodings match the core decoder's Store/Load control fields.
package lsu_pkg;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b011,
        LHU = 3'b100
    } load_type_e;

    typedef enum logic [1:0] {
        SB = 2'b00,
        SH = 2'b01,
        SW = 2'b10
    } store_type_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS,
        S_WAIT,
        S_RESP
    } lsu_state_e;

    localparam int LANES  = 4;
    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the load/store unit: enables, write replication,
// access legality and load extraction with sign/zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic             load,
    input  logic             store,
    input  logic [2:0]       load_type,
    input  logic [1:0]       store_type,
    input  logic [1:0]       offset,
    input  logic [31:0]      wdata,
    input  logic [31:0]      rdata,
    output logic [LANES-1:0] be,
    output logic [31:0]      wdata_rep,
    output logic             illegal,
    output logic             misalign,
    output logic [31:0]      load_data
);

    logic        half;
    logic        word;
    logic [31:0] lane;

    always_comb begin
        half    = 1'b0;
        word    = 1'b0;
        illegal = load & store;
        if (store) begin
            unique case (store_type)
                SB:      ;
                SH:      half = 1'b1;
                SW:      word = 1'b1;
                default: illegal = 1'b1;
            endcase
        end else if (load) begin
            unique case (load_type)
                LB, LBU:  ;
                LH, LHU:  half = 1'b1;
                LW:       word = 1'b1;
                default:  illegal = 1'b1;
            endcase
        end
        misalign = (half & offset[0]) | (word & (offset != 2'b00));
    end

    always_comb begin
        be        = {LANES{1'b1}};
        wdata_rep = '0;
        if (store && !load) begin
            unique case (1'b1)
                word: begin
                    be        = 4'b1111;
                    wdata_rep = wdata;
                end
                half: begin
                    be        = offset[1] ? 4'b1100 : 4'b0011;
                    wdata_rep = {2{wdata[HALF_W-1:0]}};
                end
                default: begin
                    be        = 4'b0001 << offset;
                    wdata_rep = {LANES{wdata[BYTE_W-1:0]}};
                end
            endcase
        end
    end

    assign lane = rdata >> {offset, 3'b000};

    always_comb begin
        load_data = '0;
        unique case (load_type)
            LB:      load_data = {{24{lane[7]}}, lane[7:0]};
            LH:      load_data = {{16{lane[15]}}, lane[15:0]};
            LW:      load_data = lane;
            LBU:     load_data = {24'd0, lane[7:0]};
            LHU:     load_data = {16'd0, lane[15:0]};
            default: load_data = '0;
        endcase
    end

endmodule

// File: rtl/lsu_mem_if.sv
// Load/store unit: one access in flight, executes decoder Store/Load
// requests on the data-memory bus with misalign, illegal and timeout errors.
module lsu_mem_if
    import lsu_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_load,
    input  logic              req_store,
    input  logic [2:0]        req_load_type,
    input  logic [1:0]        req_store_type,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LANES-1:0]  mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    lsu_state_e state_q, state_d;

    logic [CNT_W-1:0]  cnt_q;
    logic              load_q, store_q;
    logic [2:0]        ltype_q;
    logic [1:0]        stype_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              idle, in_bus, in_wait, in_resp;
    logic              accept, tmo;

    logic              a_load, a_store;
    logic [2:0]        a_ltype;
    logic [1:0]        a_stype;
    logic [1:0]        a_off;
    logic [DATA_W-1:0] a_wdata;
    logic [LANES-1:0]  a_be;
    logic [DATA_W-1:0] a_wrep;
    logic              a_illegal, a_misalign;
    logic [DATA_W-1:0] a_ldata;

    assign idle    = state_q == S_IDLE;
    assign in_bus  = state_q == S_BUS;
    assign in_wait = state_q == S_WAIT;
    assign in_resp = state_q == S_RESP;
    assign accept  = idle & req_valid;
    assign tmo     = cnt_q >= TMO_LAST;

    // Checks the incoming request in IDLE, the held request afterwards.
    assign a_load  = idle ? req_load       : load_q;
    assign a_store = idle ? req_store      : store_q;
    assign a_ltype = idle ? req_load_type  : ltype_q;
    assign a_stype = idle ? req_store_type : stype_q;
    assign a_off   = idle ? req_addr[1:0]  : addr_q[1:0];
    assign a_wdata = idle ? req_wdata      : wdata_q;

    lsu_align u_align (
        .load       (a_load),
        .store      (a_store),
        .load_type  (a_ltype),
        .store_type (a_stype),
        .offset     (a_off),
        .wdata      (a_wdata),
        .rdata      (mem_rdata),
        .be         (a_be),
        .wdata_rep  (a_wrep),
        .illegal    (a_illegal),
        .misalign   (a_misalign),
        .load_data  (a_ldata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            load_q  <= 1'b0;
            store_q <= 1'b0;
            ltype_q <= '0;
            stype_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            if (accept) begin
                cnt_q   <= '0;
                load_q  <= req_load;
                store_q <= req_store;
                ltype_q <= req_load_type;
                stype_q <= req_store_type;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end else if (in_bus || in_wait) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    rdata_d = '0;
                    err_d   = 1'b0;
                    if (!req_load && !req_store) begin
                        state_d = S_RESP;
                    end else if (a_illegal || a_misalign) begin
                        state_d = S_RESP;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_BUS;
                    end
                end
            end
            S_BUS: begin
                if (mem_ready) begin
                    state_d = store_q ? S_RESP : S_WAIT;
                end else if (tmo) begin
                    state_d = S_RESP;
                    err_d   = 1'b1;
                end
            end
            // rvalid only counts from the cycle after the handshake
            S_WAIT: begin
                if (mem_rvalid) begin
                    state_d = S_RESP;
                    rdata_d = a_ldata;
                end else if (tmo) begin
                    state_d = S_RESP;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign req_ready  = idle;
    assign busy       = !idle;
    assign mem_valid  = in_bus;
    assign mem_we     = in_bus & store_q;
    assign mem_addr   = in_bus ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign mem_be     = in_bus ? a_be : '0;
    assign mem_wdata  = in_bus ? a_wrep : '0;
    assign resp_valid = in_resp;
    assign resp_err   = in_resp & err_q;
    assign resp_rdata = in_resp ? rdata_q : '0;

endmodule

// File: tb/tb_lsu_mem_if.sv
// Directed scoreboard bench for lsu_mem_if with a cycle-level bus responder.
// Expected responses are queued on issue and popped on resp_valid.
module tb_lsu_mem_if;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_load, req_store;
    logic [2:0]  req_load_type;
    logic [1:0]  req_store_type;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_valid, mem_ready, mem_we, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        busy;

    always #5 clk = ~clk;

    lsu_mem_if #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_load       (req_load),
        .req_store      (req_store),
        .req_load_type  (req_load_type),
        .req_store_type (req_store_type),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .mem_valid      (mem_valid),
        .mem_ready      (mem_ready),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_be         (mem_be),
        .mem_wdata      (mem_wdata),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .busy           (busy)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [31:0] lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // rv_dly: cycles after the handshake cycle until rvalid (<0 = never).
    // stray: also pulse rvalid with junk data in the handshake cycle.
    task automatic run(input string tag,
                       input logic ld, input logic st,
                       input logic [2:0] lt, input logic [1:0] sty,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input int rdy_dly, input int rv_dly,
                       input logic [31:0] rd, input logic stray,
                       input logic [31:0] e_rdata, input logic e_err,
                       input int e_lat, input logic e_bus,
                       input logic [3:0] e_be, input logic [31:0] e_wd);
        exp_t e;
        int   k, hs, bus_cyc;
        logic got, bus_seen;
        sb_q.push_back('{rdata: e_rdata, err: e_err, lat: 32'(e_lat)});
        @(negedge clk);
        req_valid      = 1'b1;
        req_load       = ld;
        req_store      = st;
        req_load_type  = lt;
        req_store_type = sty;
        req_addr       = addr;
        req_wdata      = wd;
        check({tag, " req_ready"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_load  = 1'b0;
        req_store = 1'b0;
        k = 1; hs = -1; bus_cyc = 0;
        got = 1'b0; bus_seen = 1'b0;
        while (!got && k <= 40) begin
            mem_ready  = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
            if (mem_valid) begin
                mem_ready = (bus_cyc == rdy_dly);
                bus_cyc++;
                if (mem_ready) begin
                    hs = k;
                    if (stray) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = ~rd;
                    end
                end
            end
            if (hs >= 0 && rv_dly >= 0 && k == hs + rv_dly) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rd;
            end
            @(negedge clk);
            if (mem_valid) begin
                bus_seen = 1'b1;
                check({tag, " mem_addr"}, mem_addr, addr & 32'hFFFF_FFFC);
                check({tag, " mem_be"}, 32'(mem_be), 32'(e_be));
                check({tag, " mem_we"}, 32'(mem_we), 32'(st));
                check({tag, " mem_wdata"}, mem_wdata, e_wd);
            end
            if (resp_valid) begin
                got = 1'b1;
                e = sb_q.pop_front();
                check({tag, " rdata"}, resp_rdata, e.rdata);
                check({tag, " err"}, 32'(resp_err), 32'(e.err));
                check({tag, " latency"}, 32'(k), e.lat);
                check({tag, " mem_valid@resp"}, 32'(mem_valid), 32'd0);
            end
            @(posedge clk);
            #1;
            k++;
        end
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        check({tag, " resp seen"}, 32'(got), 32'd1);
        check({tag, " bus used"}, 32'(bus_seen), 32'(e_bus));
        check({tag, " single pulse"}, 32'(resp_valid), 32'd0);
        check({tag, " ready after"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
        req_load_type = '0; req_store_type = '0;
        req_addr = '0; req_wdata = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        check("rst req_ready", 32'(req_ready), 32'd1);
        check("rst busy", 32'(busy), 32'd0);
        check("rst mem_valid", 32'(mem_valid), 32'd0);
        check("rst resp_valid", 32'(resp_valid), 32'd0);
        check("rst mem_be", 32'(mem_be), 32'd0);

        //   tag     ld st  lt      sty    addr          wdata        rdy rv  rdata        stray  e_rdata      err lat bus  be       wdata
        run("sw",    0, 1, 3'd0, 2'b10, 32'h100, 32'hDEADBEEF, 0, -1, 32'h0,        0, 32'h0,        0, 2, 1, 4'b1111, 32'hDEADBEEF);
        run("sb3",   0, 1, 3'd0, 2'b00, 32'h103, 32'h000000A5, 0, -1, 32'h0,        0, 32'h0,        0, 2, 1, 4'b1000, 32'hA5A5A5A5);
        run("sb1",   0, 1, 3'd0, 2'b00, 32'h101, 32'h1234563C, 1, -1, 32'h0,        0, 32'h0,        0, 3, 1, 4'b0010, 32'h3C3C3C3C);
        run("sh2",   0, 1, 3'd0, 2'b01, 32'h102, 32'h7777ABCD, 0, -1, 32'h0,        0, 32'h0,        0, 2, 1, 4'b1100, 32'hABCDABCD);
        run("lb",    1, 0, 3'd0, 2'b00, 32'h102, 32'h0,        0,  1, 32'h00800000, 0, 32'hFFFFFF80, 0, 3, 1, 4'b1111, 32'h0);
        run("lbu",   1, 0, 3'd3, 2'b00, 32'h102, 32'h0,        0,  1, 32'h00800000, 0, 32'h00000080, 0, 3, 1, 4'b1111, 32'h0);
        run("lhu",   1, 0, 3'd4, 2'b00, 32'h102, 32'h0,        0,  1, 32'hBEEF1234, 0, 32'h0000BEEF, 0, 3, 1, 4'b1111, 32'h0);
        run("lh",    1, 0, 3'd1, 2'b00, 32'h102, 32'h0,        0,  1, 32'hBEEF1234, 0, 32'hFFFFBEEF, 0, 3, 1, 4'b1111, 32'h0);
        run("lw_st", 1, 0, 3'd2, 2'b00, 32'h104, 32'h0,        0,  2, 32'h12345678, 1, 32'h12345678, 0, 4, 1, 4'b1111, 32'h0);
        run("lh_mis",1, 0, 3'd1, 2'b00, 32'h101, 32'h0,        0,  1, 32'h0,        0, 32'h0,        1, 1, 0, 4'b1111, 32'h0);
        run("lw_mis",1, 0, 3'd2, 2'b00, 32'h102, 32'h0,        0,  1, 32'h0,        0, 32'h0,        1, 1, 0, 4'b1111, 32'h0);
        run("lt101", 1, 0, 3'd5, 2'b00, 32'h100, 32'h0,        0,  1, 32'h0,        0, 32'h0,        1, 1, 0, 4'b1111, 32'h0);
        run("st11",  0, 1, 3'd0, 2'b11, 32'h100, 32'h0,        0, -1, 32'h0,        0, 32'h0,        1, 1, 0, 4'b1111, 32'h0);
        run("ldst",  1, 1, 3'd2, 2'b10, 32'h100, 32'h0,        0,  1, 32'h0,        0, 32'h0,        1, 1, 0, 4'b1111, 32'h0);
        run("noop",  0, 0, 3'd2, 2'b10, 32'h100, 32'h0,        0,  1, 32'h0,        0, 32'h0,        0, 1, 0, 4'b1111, 32'h0);
        run("lw_slw",1, 0, 3'd2, 2'b00, 32'h208, 32'h0,        3,  4, 32'hCAFEF00D, 0, 32'hCAFEF00D, 0, 9, 1, 4'b1111, 32'h0);
        run("lw_tmo",1, 0, 3'd2, 2'b00, 32'h20C, 32'h0,        0, -1, 32'h0,        0, 32'h0,        1, TMO + 1, 1, 4'b1111, 32'h0);
        run("sw_tmo",0, 1, 3'd0, 2'b10, 32'h210, 32'h11223344, 100, -1, 32'h0,      0, 32'h0,        1, TMO + 1, 1, 4'b1111, 32'h11223344);

        // abort a load in WAIT, then feed it a late rvalid
        @(negedge clk);
        req_valid = 1'b1; req_load = 1'b1; req_store = 1'b0;
        req_load_type = 3'd2; req_addr = 32'h300;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_load = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        check("abort busy in wait", 32'(busy), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5555AAAA;
        check("abort req_ready", 32'(req_ready), 32'd1);
        check("abort mem_valid", 32'(mem_valid), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort no resp", 32'(resp_valid), 32'd0);
            mem_rvalid = 1'b0;
        end
        run("post",  1, 0, 3'd3, 2'b00, 32'h301, 32'h0,        0,  1, 32'h0000A500, 0, 32'h000000A5, 0, 3, 1, 4'b1111, 32'h0);

        check("sb drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_mem_if.md
Name: lsu_mem_if

Overview:
- Load/store unit that consumes the core decoder's Store/Load control encoding and executes the access on the data-memory bus.
- Generates byte enables and lane-replicated write data. Selects and sign/zero-extends the load data.
- Handles misalignment, illegal codes and bus timeout.
- Sits between the execute stage (request side) and the data memory / bus fabric (mem side). One access in flight at a time.

Parameters:
- ADDR_W, 32, byte-address width
- DATA_W, 32, bus data width; fixed at 32, 4 byte lanes
- TIMEOUT, 255, maximum cycles in BUS+WAIT before an error response is returned

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request offered
- req_ready  out  1  unit can accept a request
- req_load  in  1  request is a load
- req_store  in  1  request is a store
- req_load_type  in  3  000 lb, 001 lh, 010 lw, 011 lbu, 100 lhu; others illegal
- req_store_type  in  2  00 byte, 01 half, 10 word; 11 illegal
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  qualifies resp_valid: misaligned, illegal code or timeout
- mem_valid  out  1  bus request
- mem_ready  in  1  bus accepts request
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_W  word-aligned address, addr[1:0] = 00
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated write data
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read data
- busy  out  1  state != IDLE

Behaviour:
- Reset (sync):
  - state = IDLE, timeout counter = 0.
  - All outputs 0 except req_ready = 1.
- FSM states: IDLE, BUS, WAIT, RESP.
- IDLE:
  - req_ready = 1. Accept on req_valid & req_ready and register the request.
  - Neither load nor store: RESP with err = 0, rdata = 0.
  - Both load and store asserted: RESP with err = 1.
  - Illegal type or misaligned access: RESP with err = 1, no bus access.
    - Misaligned means half with addr[0] = 1, or word with addr[1:0] != 0.
  - Otherwise go to BUS.
- BUS:
  - mem_valid = 1. mem_addr, mem_we, mem_be and mem_wdata are held stable until mem_ready.
  - On mem_ready, a store goes to RESP with err = 0; a load goes to WAIT.
- WAIT:
  - Waits for mem_rvalid, then captures the extended data and goes to RESP.
  - mem_rvalid in the same cycle as the mem_ready handshake is ignored; the earliest accepted rvalid is the cycle after.
- RESP:
  - resp_valid = 1 for exactly one cycle; no back-pressure. Then IDLE.
  - req_ready = 0 in every state except IDLE.
- Timeout:
  - Counter clears on accept and increments each cycle in BUS or WAIT.
  - When it reaches TIMEOUT: mem_valid drops, RESP with err = 1, rdata = 0.
- Store lanes (o = addr[1:0]):
  - byte: be = 1 << o, wdata = {4{wdata[7:0]}}.
  - half: be = o[1] ? 1100 : 0011, wdata = {2{wdata[15:0]}}.
  - word: be = 1111, wdata unchanged.
  - Loads drive be = 1111, mem_we = 0, mem_wdata = 0.
- Load select: lane = mem_rdata >> (8*o). lb/lh sign-extend bit 7/15; lbu/lhu zero-extend; lw passes through.
- Latency from the accept cycle (T0):
  - Store with mem_ready at T1: resp_valid at T2.
  - Load with mem_ready at T1 and rvalid at T2: resp_valid at T3.
  - Error or no-op: resp_valid at T1.
- Reset mid-operation:
  - Next edge returns to IDLE and drops mem_valid.
  - No resp_valid is produced for the aborted request.
  - A stray mem_rvalid in IDLE or BUS is ignored.

Decomposition:
- lsu_pkg:
  - load_type_e (LB, LH, LW, LBU, LHU) and store_type_e (SB, SH, SW) with the encodings above.
  - lsu_state_e.
  - Lane-width constants.
- Sub-module lsu_align: purely combinational.
  - Computes be, wdata replication, misalign/illegal flags and load extraction/extension.
  - The FSM instantiates it once.

Test Plan:
- sw 0xDEADBEEF to addr 0x100, mem_ready immediate -> mem_be = 1111, mem_addr = 0x100, mem_wdata = 0xDEADBEEF, resp_valid at T2, err = 0.
- sb 0x000000A5 to addr 0x103 -> mem_be = 1000, mem_wdata = 0xA5A5A5A5, mem_addr = 0x100.
- lb at addr 0x102, mem_rdata = 0x0080_0000 -> resp_rdata = 0xFFFFFF80; lbu at the same address -> 0x00000080; lhu at addr 0x102, mem_rdata = 0xBEEF_1234 -> 0x0000BEEF.
- lh at addr 0x101 or lw at addr 0x102 -> resp_valid at T1, err = 1, mem_valid never asserted; load_type 101 -> same.
- Load with mem_ready held low for 3 cycles and rvalid 5 cycles later -> bus fields stable throughout BUS, single resp_valid; with rvalid never arriving and TIMEOUT = 8 -> err = 1 at 8 cycles, mem_valid low afterwards.
- reset asserted in WAIT, then mem_rvalid arrives after reset -> no resp_valid, req_ready = 1, next request proceeds normally.
